// File: rtl/dnn_pkg.sv
// Shared widths and the packed activation vector type for the DNN datapath.
package dnn_pkg;
  localparam int MAC_W     = 17;
  localparam int ACT_W     = 7;
  localparam int ACT_SHIFT = 6;
  localparam int ACT_MAX   = (1 << (ACT_W - 1)) - 1;
  localparam int LANES     = 4;

  typedef logic [LANES-1:0][ACT_W-1:0] act_vec_t;
endpackage

// File: rtl/dnn_relu_quant.sv
// One activation lane: ReLU, arithmetic right shift, saturate to the positive range of OUT_W.
module dnn_relu_quant #(
  parameter int IN_W  = 17,
  parameter int OUT_W = 7,
  parameter int SH    = 6
) (
  input  logic signed [IN_W-1:0]  din,
  output logic        [OUT_W-1:0] dout
);
  localparam logic [IN_W-1:0] MAX_Q = IN_W'((1 << (OUT_W - 1)) - 1);

  logic [IN_W-1:0] r;
  logic [IN_W-1:0] q;

  always_comb begin
    r = '0;
    if (!din[IN_W-1]) r = din;
    // r is non-negative, so a logical shift truncates toward zero
    q = r >> SH;
    dout = (q > MAX_Q) ? MAX_Q[OUT_W-1:0] : q[OUT_W-1:0];
  end
endmodule

// File: rtl/dnn_act_stage.sv
// Activation stage: captures MAC results, applies ReLU/requantization and buffers vectors in a
// small FIFO feeding the next layer; vectors arriving while full are dropped and flagged.
module dnn_act_stage
  import dnn_pkg::*;
#(
  parameter int IN_SIZE  = MAC_W,
  parameter int OUT_SIZE = ACT_W,
  parameter int SHIFT    = ACT_SHIFT,
  parameter int DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mac_ready,
  input  logic signed [IN_SIZE-1:0]  in4,
  input  logic signed [IN_SIZE-1:0]  in5,
  input  logic signed [IN_SIZE-1:0]  in6,
  input  logic signed [IN_SIZE-1:0]  in7,
  input  logic                       out_ready,
  input  logic                       clr_ovf,
  output logic signed [OUT_SIZE-1:0] y0,
  output logic signed [OUT_SIZE-1:0] y1,
  output logic signed [OUT_SIZE-1:0] y2,
  output logic signed [OUT_SIZE-1:0] y3,
  output logic                       out_valid,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic signed [IN_SIZE-1:0] lane_in [LANES];
  act_vec_t                  lane_q;
  act_vec_t                  s1_data_reg;
  logic                      s1_valid_reg;
  act_vec_t                  mem [DEPTH];
  act_vec_t                  head;
  logic [PW-1:0]             wr_ptr_reg;
  logic [PW-1:0]             rd_ptr_reg;
  logic [LW-1:0]             level_reg;
  logic                      overflow_reg;
  logic                      pop;
  logic                      push;
  logic                      drop;

  assign lane_in[0] = in4;
  assign lane_in[1] = in5;
  assign lane_in[2] = in6;
  assign lane_in[3] = in7;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      dnn_relu_quant #(
        .IN_W (IN_SIZE),
        .OUT_W(OUT_SIZE),
        .SH   (SHIFT)
      ) u_lane (
        .din (lane_in[gi]),
        .dout(lane_q[gi])
      );
    end
  endgenerate

  // out_valid derives only from the registered level, never from out_ready
  assign out_valid = (level_reg != '0);
  assign pop       = out_valid && out_ready;
  // a full FIFO still accepts a vector when the head leaves on the same edge
  assign push      = s1_valid_reg && ((level_reg < DEPTH_L) || pop);
  assign drop      = s1_valid_reg && !push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      s1_valid_reg <= mac_ready;
      if (mac_ready) s1_data_reg <= lane_q;
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      level_reg <= level_reg + LW'(push) - LW'(pop);
      if (drop)         overflow_reg <= 1'b1;
      else if (clr_ovf) overflow_reg <= 1'b0;
    end
  end

  // Storage has no reset; stale entries are hidden by the out_valid gating below.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= s1_data_reg;
  end

  assign head     = mem[rd_ptr_reg];
  assign y0       = out_valid ? head[0] : '0;
  assign y1       = out_valid ? head[1] : '0;
  assign y2       = out_valid ? head[2] : '0;
  assign y3       = out_valid ? head[3] : '0;
  assign overflow = overflow_reg;
  assign level    = level_reg;
endmodule

// File: tb/tb_dnn_act_stage.sv
// Directed bench for dnn_act_stage: inputs driven and outputs sampled on the falling edge.
module tb_dnn_act_stage;
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               mac_ready = 1'b0;
  logic signed [16:0] in4 = '0, in5 = '0, in6 = '0, in7 = '0;
  logic               out_ready = 1'b0;
  logic               clr_ovf = 1'b0;
  logic signed [6:0]  y0, y1, y2, y3;
  logic               out_valid;
  logic               overflow;
  logic [2:0]         level;

  int checks = 0;
  int failures = 0;

  dnn_act_stage dut (
    .clk(clk), .rst(rst), .mac_ready(mac_ready),
    .in4(in4), .in5(in5), .in6(in6), .in7(in7),
    .out_ready(out_ready), .clr_ovf(clr_ovf),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .out_valid(out_valid), .overflow(overflow), .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic set_in(input int a, input int b, input int c, input int d);
    in4 = 17'(a); in5 = 17'(b); in6 = 17'(c); in7 = 17'(d);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_level", level, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ovf", overflow, 0);
    check("rst_y0", y0, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single vector with two-edge latency
    set_in(1000, -500, 5000, 64); mac_ready = 1'b1;
    @(negedge clk); mac_ready = 1'b0;
    check("lat_valid_k", out_valid, 0);
    @(negedge clk);
    check("lat_valid_k1", out_valid, 1);
    check("single_level", level, 1);
    check("single_y0", y0, 15);
    check("single_y1", y1, 0);
    check("single_y2", y2, 63);
    check("single_y3", y3, 1);
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    check("single_pop_level", level, 0);
    check("single_pop_y0", y0, 0);
    $display("txn single vector done");

    // Boundaries
    set_in(63, 4095, 4032, -65536); mac_ready = 1'b1;
    @(negedge clk);
    set_in(65535, 0, -1, 127);
    @(negedge clk); mac_ready = 1'b0;
    check("bnd_63", y0, 0);
    check("bnd_4095", y1, 63);
    check("bnd_4032", y2, 63);
    check("bnd_neg65536", y3, 0);
    out_ready = 1'b1;
    @(negedge clk);
    check("bnd_65535", y0, 63);
    check("bnd_zero", y1, 0);
    check("bnd_minus1", y2, 0);
    check("bnd_127", y3, 1);
    @(negedge clk); out_ready = 1'b0;
    check("bnd_drained", level, 0);
    $display("txn boundaries done");

    // Fill and overflow: fifth vector is lost
    for (int n = 1; n <= 5; n++) begin
      set_in(64 * n, 0, 0, 0); mac_ready = 1'b1;
      @(negedge clk);
    end
    mac_ready = 1'b0;
    @(negedge clk);
    check("fill_level", level, 4);
    check("fill_ovf", overflow, 1);
    out_ready = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      check($sformatf("drain_y0_%0d", n), y0, n);
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("drain_level", level, 0);
    check("drain_ovf_sticky", overflow, 1);
    clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    check("clr_ovf", overflow, 0);
    $display("txn fill/overflow done");

    // Full with simultaneous push and pop, across pointer wrap
    for (int n = 1; n <= 4; n++) begin
      set_in(64 * n, 0, 0, 0); mac_ready = 1'b1;
      @(negedge clk);
    end
    mac_ready = 1'b0;
    @(negedge clk);
    for (int i = 5; i <= 16; i++) begin
      check($sformatf("full_level_%0d", i), level, 4);
      if (i > 5) check($sformatf("full_head_%0d", i), y0, i - 5);
      set_in(64 * i, 0, 0, 0); mac_ready = 1'b1;
      out_ready = (i > 5);
      @(negedge clk);
    end
    mac_ready = 1'b0;
    check("full_ovf", overflow, 0);
    for (int h = 12; h <= 16; h++) begin
      check($sformatf("wrap_head_%0d", h), y0, h);
      @(negedge clk);
    end
    check("wrap_empty", level, 0);
    @(negedge clk);
    out_ready = 1'b0;
    check("ready_empty_level", level, 0);
    $display("txn full push/pop done");

    // Reset mid-stream with stage 1 occupied
    for (int n = 1; n <= 4; n++) begin
      set_in(64 * n, 0, 0, 0); mac_ready = 1'b1;
      @(negedge clk);
    end
    mac_ready = 1'b0;
    check("mid_level", level, 3);
    #2 rst = 1'b1;
    #1;
    check("async_y0", y0, 0);
    check("async_level", level, 0);
    check("async_valid", out_valid, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", out_valid, 0);
    set_in(448, 0, 0, 0); mac_ready = 1'b1;
    @(negedge clk); mac_ready = 1'b0;
    check("post_rst_lat_k", out_valid, 0);
    @(negedge clk);
    check("post_rst_lat_k1", out_valid, 1);
    check("post_rst_y0", y0, 7);
    check("post_rst_level", level, 1);
    $display("txn reset mid-stream done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
